// File: rtl/ro_pkg.sv
// -----------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the ring-oscillator measurement blocks.
//   - ro_state_e : measurement FSM state encoding
//   - RO_*_DEF   : default window / warm-up / counter-width constants, shared
//                  with the entropy-sampler blocks
//   - ro_max     : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package ro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } ro_state_e;

    localparam int RO_WINDOW_CYCLES_DEF = 1024;
    localparam int RO_WARMUP_CYCLES_DEF = 16;
    localparam int RO_CNT_WIDTH_DEF     = 16;

    function automatic int ro_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ro_pkg

// File: rtl/ro_sync_edge.sv
// -----------------------------------------------------------------------------
// ro_sync_edge
// Brings the free-running oscillator output into the iClk domain through a
// two-flop synchroniser, then a third flop for edge detection.
//   iClk    : system clock
//   iRstN   : asynchronous active-low reset, clears all three flops
//   iAsync  : raw asynchronous input (oscillator output)
//   oRise   : one-cycle pulse per rising edge seen in the iClk domain
// -----------------------------------------------------------------------------
module ro_sync_edge (
    input  logic iClk,
    input  logic iRstN,
    input  logic iAsync,
    output logic oRise
);

    (* ASYNC_REG = "TRUE" *) logic r_s1;
    (* ASYNC_REG = "TRUE" *) logic r_s2;
    logic                          r_s3;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift in one
            // edge; blocking ones would collapse the chain into a single flop.
            r_s1 <= iAsync;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign oRise = r_s2 & ~r_s3;

endmodule : ro_sync_edge

// File: rtl/ro_freq_counter.sv
// -----------------------------------------------------------------------------
// ro_freq_counter
// Enables the ring oscillator, waits WARMUP_CYCLES for it to settle, counts its
// rising edges over WINDOW_CYCLES system clocks, and returns the count through
// a valid/ready handshake. Oscillators faster than iClk/2 alias; the count is
// then only a relative metric.
//   iClk      : system clock
//   iRstN     : asynchronous active-low reset
//   iStart    : single-cycle measurement request (honoured in IDLE only)
//   iOsc      : raw oscillator output, asynchronous to iClk
//   oEn       : oscillator enable (high in WARMUP and MEASURE)
//   oBusy     : high from accepted start until the result handshake
//   oCount    : rising-edge count of the last completed window
//   oOverflow : edge counter saturated during the last window
//   oValid    : result valid (HOLD state)
//   iReady    : consumer accepts the result
// -----------------------------------------------------------------------------
module ro_freq_counter
    import ro_pkg::*;
#(
    parameter int WINDOW_CYCLES = RO_WINDOW_CYCLES_DEF,
    parameter int WARMUP_CYCLES = RO_WARMUP_CYCLES_DEF,
    parameter int CNT_WIDTH     = RO_CNT_WIDTH_DEF
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iStart,
    input  logic                 iOsc,
    output logic                 oEn,
    output logic                 oBusy,
    output logic [CNT_WIDTH-1:0] oCount,
    output logic                 oOverflow,
    output logic                 oValid,
    input  logic                 iReady
);

    // Phase counter holds "cycles left minus one"; sized for the longer phase.
    localparam int                CYC_W       = $clog2(ro_max(WINDOW_CYCLES, WARMUP_CYCLES) + 1);
    localparam logic [CYC_W-1:0] WARMUP_LOAD = CYC_W'(WARMUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] WINDOW_LOAD = CYC_W'(WINDOW_CYCLES - 1);

    ro_state_e            r_state;
    ro_state_e            w_state_nxt;
    logic [CYC_W-1:0]     r_cyc;
    logic [CNT_WIDTH-1:0] r_edge;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;
    logic                 w_rise;
    logic                 w_cyc_done;
    logic [CNT_WIDTH-1:0] w_edge_nxt;
    logic                 w_ovf_nxt;

    ro_sync_edge u_sync (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iAsync (iOsc),
        .oRise  (w_rise)
    );

    assign w_cyc_done = (r_cyc == '0);

    // State register. oEn/oBusy/oValid decode directly from it, so an
    // asynchronous reset drops oEn without waiting for a clock edge.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt = r_state;
        oEn         = 1'b0;
        oBusy       = 1'b1;
        oValid      = 1'b0;
        case (r_state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) w_state_nxt = WARMUP;
            end
            WARMUP: begin
                oEn = 1'b1;
                if (w_cyc_done) w_state_nxt = MEASURE;
            end
            MEASURE: begin
                oEn = 1'b1;
                if (w_cyc_done) w_state_nxt = HOLD;
            end
            HOLD: begin
                oValid = 1'b1;
                if (iReady) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Saturating edge count including this cycle's pulse. Overflow marks an
    // edge that arrived while the counter was already at all-ones (lost edge).
    always_comb begin
        w_edge_nxt = r_edge;
        w_ovf_nxt  = r_ovf;
        if (w_rise) begin
            if (&r_edge) w_ovf_nxt  = 1'b1;
            else         w_edge_nxt = r_edge + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_cyc      <= '0;
            r_edge     <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // oCount deliberately survives a new start until the next
                    // result is published.
                    if (iStart) begin
                        r_cyc      <= WARMUP_LOAD;
                        r_edge     <= '0;
                        r_ovf      <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (w_cyc_done) r_cyc <= WINDOW_LOAD;
                    else            r_cyc <= r_cyc - 1'b1;
                end
                MEASURE: begin
                    r_edge <= w_edge_nxt;
                    r_ovf  <= w_ovf_nxt;
                    if (w_cyc_done) begin
                        r_count    <= w_edge_nxt;
                        r_overflow <= w_ovf_nxt;
                    end else begin
                        r_cyc <= r_cyc - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oCount    = r_count;
    assign oOverflow = r_overflow;

endmodule : ro_freq_counter

// File: tb/tb_ro_freq_counter.sv
// -----------------------------------------------------------------------------
// tb_ro_freq_counter
// Directed bench for ro_freq_counter. Instance A uses the default parameters
// (WINDOW=1024, WARMUP=16, CNT_WIDTH=16); instance B uses CNT_WIDTH=4,
// WINDOW=64 for saturation. Each oscillator model toggles only while its
// oEn is high, with a period chosen per test (0 = held low).
// -----------------------------------------------------------------------------
module tb_ro_freq_counter;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        start_a, ready_a, osc_a, en_a, busy_a, valid_a, ovf_a;
    logic [15:0] count_a;
    logic        start_b, ready_b, osc_b, en_b, busy_b, valid_b, ovf_b;
    logic [3:0]  count_b;

    int period_a = 0;
    int period_b = 0;
    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int en_n;

    always #5 iClk = ~iClk;

    ro_freq_counter u_dut_a (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iStart    (start_a),
        .iOsc      (osc_a),
        .oEn       (en_a),
        .oBusy     (busy_a),
        .oCount    (count_a),
        .oOverflow (ovf_a),
        .oValid    (valid_a),
        .iReady    (ready_a)
    );

    ro_freq_counter #(
        .WINDOW_CYCLES (64),
        .WARMUP_CYCLES (16),
        .CNT_WIDTH     (4)
    ) u_dut_b (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iStart    (start_b),
        .iOsc      (osc_b),
        .oEn       (en_b),
        .oBusy     (busy_b),
        .oCount    (count_b),
        .oOverflow (ovf_b),
        .oValid    (valid_b),
        .iReady    (ready_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Oscillator models: square wave of the given period while oEn is high.
    initial begin
        int ph;
        ph    = 0;
        osc_a = 1'b0;
        forever begin
            @(posedge iClk);
            #2;
            if (period_a == 0 || !en_a) begin
                ph    = 0;
                osc_a = 1'b0;
            end else begin
                ph    = (ph + 1) % period_a;
                osc_a = (ph < period_a / 2);
            end
        end
    end

    initial begin
        int ph;
        ph    = 0;
        osc_b = 1'b0;
        forever begin
            @(posedge iClk);
            #2;
            if (period_b == 0 || !en_b) begin
                ph    = 0;
                osc_b = 1'b0;
            end else begin
                ph    = (ph + 1) % period_b;
                osc_b = (ph < period_b / 2);
            end
        end
    end

    // Pulse iStart, then run until oValid (bounded). Optionally re-pulse
    // iStart at cycle poke_at, and check oCount still holds hold_exp at cycle 500.
    task automatic measure(input bit sel, input int poke_at, input int hold_exp,
                           output int lat_o, output int en_o);
        int c;
        c    = 0;
        en_o = 0;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        do begin
            step(1);
            c++;
            start_a = !sel && (c == poke_at);
            start_b =  sel && (c == poke_at);
            if (sel ? en_b : en_a) en_o++;
            if (hold_exp >= 0 && c == 500) check("count_hold", count_a, hold_exp);
        end while (!(sel ? valid_b : valid_a) && c < 3000);
        lat_o = c;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        iRstN   = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;
        step(3);
        check("rst_en",    en_a,    0);
        check("rst_busy",  busy_a,  0);
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_ovf",   ovf_a,   0);
        check("rst_b_valid", valid_b, 0);
        iRstN = 1'b1;
        step(2);

        // Nominal: period 8 over 1024 cycles -> 128 edges.
        period_a = 8;
        measure(0, 0, -1, lat, en_n);
        check("nom_latency", lat,     1041);
        check("nom_en_cyc",  en_n,    1040);
        check("nom_count",   count_a, 128);
        check("nom_ovf",     ovf_a,   0);
        check("nom_busy",    busy_a,  1);
        check("nom_en_hold", en_a,    0);

        // Handshake stall for 50 cycles.
        repeat (50) begin
            step(1);
            check("stall_valid", valid_a, 1);
            check("stall_count", count_a, 128);
            check("stall_busy",  busy_a,  1);
            check("stall_en",    en_a,    0);
        end
        ready_a = 1'b1;
        step(1);
        ready_a = 1'b0;
        check("hs_valid", valid_a, 0);
        check("hs_busy",  busy_a,  0);
        check("hs_count", count_a, 128);

        // Back-to-back: start the cycle after the handshake, period 16 -> 64.
        period_a = 16;
        measure(0, 0, 128, lat, en_n);
        check("b2b_latency", lat,     1041);
        check("b2b_count",   count_a, 64);
        check("b2b_ovf",     ovf_a,   0);
        ready_a = 1'b1;
        step(1);
        ready_a = 1'b0;
        check("b2b_hs_busy", busy_a, 0);

        // Idle oscillator, with iStart re-pulsed mid-MEASURE (ignored).
        period_a = 0;
        measure(0, 600, -1, lat, en_n);
        check("idle_latency", lat,     1041);
        check("idle_count",   count_a, 0);
        check("idle_ovf",     ovf_a,   0);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check("hold_start_valid", valid_a, 1);
        check("hold_start_busy",  busy_a,  1);
        start_a = 1'b1;
        ready_a = 1'b1;
        step(1);
        start_a = 1'b0;
        ready_a = 1'b0;
        check("hs_start_valid", valid_a, 0);
        check("hs_start_busy",  busy_a,  0);
        step(1);
        check("hs_start_ignored", busy_a, 0);
        check("hs_start_en",      en_a,   0);

        // Reset mid-MEASURE: outputs drop without a clock edge.
        period_a = 8;
        start_a  = 1'b1;
        step(1);
        start_a = 1'b0;
        step(599);
        check("pre_rst_en", en_a, 1);
        iRstN = 1'b0;
        #1;
        check("mid_rst_en",    en_a,    0);
        check("mid_rst_busy",  busy_a,  0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_count", count_a, 0);
        step(2);
        iRstN = 1'b1;
        step(1);
        check("post_rst_busy", busy_a, 0);
        measure(0, 0, -1, lat, en_n);
        check("post_rst_latency", lat,     1041);
        check("post_rst_count",   count_a, 128);
        ready_a = 1'b1;
        step(1);
        ready_a = 1'b0;

        // Saturation on the 4-bit instance: 32 edges in 64 cycles.
        period_b = 2;
        measure(1, 0, -1, lat, en_n);
        check("sat_latency", lat,     81);
        check("sat_en_cyc",  en_n,    80);
        check("sat_count",   count_b, 15);
        check("sat_ovf",     ovf_b,   1);
        ready_b = 1'b1;
        step(1);
        ready_b = 1'b0;
        check("sat_hs_valid", valid_b, 0);
        check("sat_hs_ovf",   ovf_b,   1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ro_freq_counter
